stash_path_packer: RTL and testbench



---
 rtl/stash_path_packer_pkg.sv | 40 ++++
 rtl/stash_path_packer_hdr.sv | 64 ++++++
 rtl/stash_path_packer.sv | 150 +++++++++++++++
 tb/tb_stash_path_packer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/stash_path_packer_pkg.sv
// Shared bucket-layout constants for the stash, the path packer and the DRAM header parser.
// Header layout, LSB first: valid[Z-1:0], PAddr[0..Z-1], Leaf[0..Z-1], zero-padded to whole beats.
package stash_path_packer_pkg;

   localparam int DataWidthDef   = 64;
   localparam int ORAMBDef       = 512;
   localparam int ORAMUDef       = 32;
   localparam int ORAMLDef       = 32;
   localparam int ORAMZDef       = 4;
   localparam int PathBucketsDef = ORAMLDef + 1;

   localparam logic [ORAMUDef-1:0] DummyBlockAddress = '1;

   function automatic int hdr_width(int z, int u, int l);
      return z * (1 + u + l);
   endfunction

   function automatic int hdr_beats(int z, int u, int l, int dw);
      return (hdr_width(z, u, l) + dw - 1) / dw;
   endfunction

   function automatic int hdr_paddr_off(int z, int u, int slot);
      return z + slot * u;
   endfunction

   function automatic int hdr_leaf_off(int z, int u, int l, int slot);
      return z + z * u + slot * l;
   endfunction

   localparam int BlockBeats  = ORAMBDef / DataWidthDef;
   localparam int HeaderWidth = hdr_width(ORAMZDef, ORAMUDef, ORAMLDef);
   localparam int HeaderBeats = hdr_beats(ORAMZDef, ORAMUDef, ORAMLDef, DataWidthDef);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_HEADER
   } pack_state_e;

endpackage

// File: rtl/stash_path_packer_hdr.sv
// Z-slot bucket header register; serializes the padded header one beat per advance.
module bucket_header_serializer
   import stash_path_packer_pkg::*;
#(
   parameter int DataWidth = DataWidthDef,
   parameter int ORAMU     = ORAMUDef,
   parameter int ORAML     = ORAMLDef,
   parameter int ORAMZ     = ORAMZDef,
   parameter int SlotW     = (ORAMZ > 1) ? $clog2(ORAMZ) : 1
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 clear_i,
   input  logic                 load_i,
   input  logic [SlotW-1:0]     slot_i,
   input  logic                 valid_i,
   input  logic [ORAMU-1:0]     paddr_i,
   input  logic [ORAML-1:0]     leaf_i,
   input  logic                 advance_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 last_o
);

   localparam int HdrBeats = hdr_beats(ORAMZ, ORAMU, ORAML, DataWidth);
   localparam int PadWidth = HdrBeats * DataWidth;
   localparam int CntW     = (HdrBeats > 1) ? $clog2(HdrBeats) : 1;

   logic [ORAMZ-1:0]    valid_q;
   logic [ORAMU-1:0]    paddr_q [ORAMZ];
   logic [ORAML-1:0]    leaf_q  [ORAMZ];
   logic [CntW-1:0]     cnt_q;
   logic [PadWidth-1:0] hdr_vec;

   always_ff @(posedge Clock) begin
      if (Reset || clear_i) begin
         valid_q <= '0;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < ORAMZ; i++) begin
            paddr_q[i] <= '0;
            leaf_q[i]  <= '0;
         end
      end else begin
         if (load_i) begin
            valid_q[slot_i] <= valid_i;
            paddr_q[slot_i] <= paddr_i;
            leaf_q[slot_i]  <= leaf_i;
         end
         if (advance_i) cnt_q <= last_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_comb begin
      hdr_vec = '0;
      hdr_vec[ORAMZ-1:0] = valid_q;
      for (int unsigned i = 0; i < ORAMZ; i++) begin
         hdr_vec[hdr_paddr_off(ORAMZ, ORAMU, int'(i)) +: ORAMU]       = paddr_q[i];
         hdr_vec[hdr_leaf_off(ORAMZ, ORAMU, ORAML, int'(i)) +: ORAML] = leaf_q[i];
      end
   end

   assign data_o = hdr_vec[int'(cnt_q) * DataWidth +: DataWidth];
   assign last_o = (cnt_q == CntW'(HdrBeats - 1));

endmodule

// File: rtl/stash_path_packer.sv
// Packs the stash writeback stream into DRAM bucket order: Z blocks of data passed through
// with zero latency, then the serialized bucket header, for every bucket on the path.
module stash_path_packer
   import stash_path_packer_pkg::*;
#(
   parameter int DataWidth   = DataWidthDef,
   parameter int ORAMB       = ORAMBDef,
   parameter int ORAMU       = ORAMUDef,
   parameter int ORAML       = ORAMLDef,
   parameter int ORAMZ       = ORAMZDef,
   parameter int PathBuckets = PathBucketsDef
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [DataWidth-1:0] ReadData,
   input  logic [ORAMU-1:0]     ReadPAddr,
   input  logic [ORAML-1:0]     ReadLeaf,
   input  logic                 ReadOutValid,
   output logic                 ReadOutReady,
   input  logic                 BlockReadComplete,
   output logic [DataWidth-1:0] DRAMData,
   output logic                 DRAMValid,
   input  logic                 DRAMReady,
   output logic                 PathWriteComplete,
   output logic                 ProtocolError
);

   localparam int BlkBeats = ORAMB / DataWidth;
   localparam int BeatW    = (BlkBeats > 1) ? $clog2(BlkBeats) : 1;
   localparam int BlkW     = $clog2(ORAMZ + 1);
   localparam int BktW     = $clog2(PathBuckets + 1);
   localparam int SlotW    = (ORAMZ > 1) ? $clog2(ORAMZ) : 1;

   pack_state_e          state_q, state_d;
   logic [BeatW-1:0]     beat_q, beat_d;
   logic [BlkW-1:0]      blk_q, blk_d;
   logic [BktW-1:0]      bkt_q, bkt_d;
   logic                 err_q, err_d;
   logic                 pwc_q, pwc_d;
   logic                 hdr_clear, hdr_load, hdr_adv, hdr_last;
   logic [DataWidth-1:0] hdr_data;
   logic                 last_beat;

   bucket_header_serializer #(
      .DataWidth (DataWidth),
      .ORAMU     (ORAMU),
      .ORAML     (ORAML),
      .ORAMZ     (ORAMZ),
      .SlotW     (SlotW)
   ) u_hdr (
      .Clock     (Clock),
      .Reset     (Reset),
      .clear_i   (hdr_clear),
      .load_i    (hdr_load),
      .slot_i    (blk_q[SlotW-1:0]),
      .valid_i   (ReadPAddr != ORAMU'(DummyBlockAddress)),
      .paddr_i   (ReadPAddr),
      .leaf_i    (ReadLeaf),
      .advance_i (hdr_adv),
      .data_o    (hdr_data),
      .last_o    (hdr_last)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         blk_q   <= '0;
         bkt_q   <= '0;
         err_q   <= 1'b0;
         pwc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         blk_q   <= blk_d;
         bkt_q   <= bkt_d;
         err_q   <= err_d;
         pwc_q   <= pwc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      blk_d        = blk_q;
      bkt_d        = bkt_q;
      err_d        = err_q;
      pwc_d        = 1'b0;
      hdr_clear    = 1'b0;
      hdr_load     = 1'b0;
      hdr_adv      = 1'b0;
      ReadOutReady = 1'b0;
      DRAMValid    = 1'b0;
      DRAMData     = '0;
      last_beat    = (beat_q == BeatW'(BlkBeats - 1));

      unique case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d   = ST_DATA;
               beat_d    = '0;
               blk_d     = '0;
               bkt_d     = '0;
               hdr_clear = 1'b1;
            end
         end
         ST_DATA: begin
            ReadOutReady = DRAMReady;
            DRAMValid    = ReadOutValid;
            DRAMData     = ReadData;
            if (ReadOutValid && DRAMReady) begin
               // Beat count decides block boundaries; a misplaced BlockReadComplete is only flagged.
               if (BlockReadComplete != last_beat) err_d = 1'b1;
               if (last_beat) begin
                  beat_d   = '0;
                  hdr_load = 1'b1;
                  blk_d    = blk_q + 1'b1;
                  if (blk_q == BlkW'(ORAMZ - 1)) state_d = ST_HEADER;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_HEADER: begin
            DRAMValid = 1'b1;
            DRAMData  = hdr_data;
            if (DRAMReady) begin
               hdr_adv = 1'b1;
               if (hdr_last) begin
                  bkt_d = bkt_q + 1'b1;
                  if (bkt_q == BktW'(PathBuckets - 1)) begin
                     pwc_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     blk_d     = '0;
                     hdr_clear = 1'b1;
                     state_d   = ST_DATA;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign PathWriteComplete = pwc_q;
   assign ProtocolError     = err_q;

endmodule

// File: tb/tb_stash_path_packer.sv
// Randomized bench: drives a stash stream and a DRAM sink, compares every DRAM beat to a path model.
module tb_stash_path_packer;

   localparam int DW        = 64;
   localparam int Z         = 4;
   localparam int BB        = 8;
   localparam int HB        = 5;
   localparam int NBKT      = 33;
   localparam int BKT_BEATS = Z * BB + HB;
   localparam logic [31:0] DUMMY = 32'hFFFF_FFFF;

   logic          Clock = 1'b0;
   logic          Reset, Start;
   logic [DW-1:0] ReadData;
   logic [31:0]   ReadPAddr, ReadLeaf;
   logic          ReadOutValid, ReadOutReady, BlockReadComplete;
   logic [DW-1:0] DRAMData;
   logic          DRAMValid, DRAMReady, PathWriteComplete, ProtocolError;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] s_data[$];
   logic [31:0] s_paddr[$];
   logic [31:0] s_leaf[$];
   logic        s_brc[$];
   logic [63:0] e_data[$];

   always #5 Clock = ~Clock;

   stash_path_packer #(
      .DataWidth   (DW),
      .ORAMB       (512),
      .ORAMU       (32),
      .ORAML       (32),
      .ORAMZ       (Z),
      .PathBuckets (NBKT)
   ) dut (
      .Clock             (Clock),
      .Reset             (Reset),
      .Start             (Start),
      .ReadData          (ReadData),
      .ReadPAddr         (ReadPAddr),
      .ReadLeaf          (ReadLeaf),
      .ReadOutValid      (ReadOutValid),
      .ReadOutReady      (ReadOutReady),
      .BlockReadComplete (BlockReadComplete),
      .DRAMData          (DRAMData),
      .DRAMValid         (DRAMValid),
      .DRAMReady         (DRAMReady),
      .PathWriteComplete (PathWriteComplete),
      .ProtocolError     (ProtocolError)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bucket 0: real blocks f0000000+k, leaf 0000ffff, data 0..31; bucket 1: blocks 1 and 3 dummy.
   task automatic build_path(input bit inject);
      logic [HB*DW-1:0] hdr;
      logic [31:0]      pa, lf;
      logic [63:0]      d;
      s_data.delete(); s_paddr.delete(); s_leaf.delete(); s_brc.delete(); e_data.delete();
      for (int b = 0; b < NBKT; b++) begin
         hdr = '0;
         for (int k = 0; k < Z; k++) begin
            if (b == 0) begin
               pa = 32'hF000_0000 + k;
               lf = 32'h0000_FFFF;
            end else if (b == 1 && (k == 1 || k == 3)) begin
               pa = DUMMY;
               lf = $urandom;
            end else begin
               pa = ($urandom_range(3, 0) == 0) ? DUMMY : $urandom;
               lf = $urandom;
            end
            hdr[k]                  = (pa != DUMMY);
            hdr[Z + 32*k +: 32]     = pa;
            hdr[Z + 32*Z + 32*k +: 32] = lf;
            for (int t = 0; t < BB; t++) begin
               d = (b == 0) ? 64'(k * BB + t) : {$urandom, $urandom};
               s_data.push_back(d);
               s_paddr.push_back(pa);
               s_leaf.push_back(lf);
               s_brc.push_back((t == BB - 1) || (inject && b == 2 && k == 1 && t == 5));
               e_data.push_back(d);
            end
         end
         for (int h = 0; h < HB; h++) e_data.push_back(hdr[DW*h +: DW]);
      end
   endtask

   task automatic run_path(input int rdy_mode, input bit inject, input bit poke_start,
                           input int abort_at, input bit do_rst);
      int          cyc, si, di, total;
      bit          sv, exp_err, hold, in_data, acc;
      logic [63:0] hold_data;
      build_path(inject);
      total = e_data.size();
      cyc = 0; si = 0; di = 0; sv = 0; exp_err = 0; hold = 0; hold_data = '0;
      if (do_rst) begin
         Reset = 1'b1; Start = 1'b0; ReadOutValid = 1'b0; DRAMReady = 1'b0;
         @(negedge Clock); @(negedge Clock);
         Reset = 1'b0;
      end
      @(negedge Clock); Start = 1'b1;
      @(negedge Clock); Start = 1'b0;
      while (di < total && cyc < 40000 && !(abort_at >= 0 && di >= abort_at)) begin
         if (!sv && si < s_data.size() && $urandom_range(3, 0) != 0) sv = 1;
         ReadOutValid = sv;
         Start = poke_start && (cyc == 50);
         if (sv) begin
            ReadData = s_data[si]; ReadPAddr = s_paddr[si];
            ReadLeaf = s_leaf[si]; BlockReadComplete = s_brc[si];
         end else begin
            ReadData = {$urandom, $urandom}; ReadPAddr = $urandom;
            ReadLeaf = $urandom; BlockReadComplete = 1'($urandom_range(1, 0));
         end
         DRAMReady = (rdy_mode == 1) ? (cyc % 3 == 0) : ($urandom_range(3, 0) != 0);
         #1;
         in_data = (di % BKT_BEATS) < Z * BB;
         check("rd_ready", 64'(ReadOutReady), 64'(in_data ? DRAMReady : 1'b0));
         check("dram_valid", 64'(DRAMValid), 64'(in_data ? sv : 1'b1));
         check("pwc_early", 64'(PathWriteComplete), 64'(0));
         check("proto_err", 64'(ProtocolError), 64'(exp_err));
         if (hold) check("stall_data", DRAMData, hold_data);
         acc = DRAMValid && DRAMReady;
         if (acc) begin
            check($sformatf("beat%0d", di), DRAMData, e_data[di]);
            di++;
         end
         if (sv && ReadOutReady) begin
            if (s_brc[si] != ((si % BB) == BB - 1)) exp_err = 1;
            si++;
            sv = 0;
         end
         hold = DRAMValid && !DRAMReady;
         hold_data = DRAMData;
         @(negedge Clock);
         cyc++;
      end
      Start = 1'b0;
      ReadOutValid = 1'b0;
      if (abort_at >= 0) begin
         Reset = 1'b1; DRAMReady = 1'b1;
         @(negedge Clock);
         Reset = 1'b0;
         for (int i = 0; i < 20; i++) begin
            #1;
            check("abort_pwc", 64'(PathWriteComplete), 64'(0));
            check("abort_valid", 64'(DRAMValid), 64'(0));
            check("abort_err", 64'(ProtocolError), 64'(0));
            @(negedge Clock);
         end
      end else begin
         check("beat_total", 64'(di), 64'(NBKT * BKT_BEATS));
         #1;
         check("pwc_pulse", 64'(PathWriteComplete), 64'(di == total));
         check("proto_err_end", 64'(ProtocolError), 64'(exp_err));
         @(negedge Clock); #1;
         check("pwc_once", 64'(PathWriteComplete), 64'(0));
         check("idle_valid", 64'(DRAMValid), 64'(0));
         check("idle_ready", 64'(ReadOutReady), 64'(0));
      end
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; ReadData = '0; ReadPAddr = '0; ReadLeaf = '0;
      ReadOutValid = 1'b0; BlockReadComplete = 1'b0; DRAMReady = 1'b1;
      @(negedge Clock); @(negedge Clock);
      check("rst_ready", 64'(ReadOutReady), 64'(0));
      check("rst_valid", 64'(DRAMValid), 64'(0));
      check("rst_data", DRAMData, 64'(0));
      check("rst_pwc", 64'(PathWriteComplete), 64'(0));
      check("rst_err", 64'(ProtocolError), 64'(0));
      Reset = 1'b0;
      run_path(0, 0, 1, -1, 1);
      run_path(1, 1, 0, -1, 1);
      run_path(0, 0, 0, 35, 1);
      run_path(0, 0, 0, -1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
